// File: rtl/store_buffer_if.sv
// Pipeline-side bus of the store buffer: load/store requests from the MEM stage,
// load data and stall back to the pipeline.
interface store_buffer_if;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata, stall
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata, stall
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the single-ported data memory.
// Stores queue in a circular FIFO and drain on any cycle the port is not taken
// by a missing load, so loads never wait behind stores.
// Optional feature macro: STORE_FWD_EN -- when defined, loads that hit a queued
// store are served from the buffer; otherwise they stall until the match drains.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal operation: accept stores, serve loads, drain when idle
// ST_FLUSH | drain only; every pipeline op is stalled until flush drops
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_buffer_if.slave        pipe,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 err,
    output logic [15:0]          dm_addr,
    output logic                 dm_re,
    output logic                 dm_we,
    output logic [15:0]          dm_wrt_data,
    input  logic [15:0]          dm_rd_data
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t             state, state_nxt;
    logic [15:0]        addr_q [DEPTH];
    logic [15:0]        data_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count;
    logic               err_q;

    logic               conflict;
    logic               hit;
    logic [15:0]        hit_data;
    logic               load_miss;
    logic               push;
    logic               pop;
    logic               full;

    assign conflict = pipe.mem_re & pipe.mem_we;
    assign full     = (count == FULL_CNT);
    assign err      = err_q;

    // Search the valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (addr_q[idx] == pipe.mem_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    // Port arbitration, stall generation and next-state decode.
    always_comb begin
        state_nxt   = state;
        load_miss   = 1'b0;
        dm_re       = 1'b0;
        dm_we       = 1'b0;
        dm_addr     = addr_q[rd_ptr];
        dm_wrt_data = data_q[rd_ptr];
        pipe.stall  = 1'b0;
        pipe.mem_rdata = dm_rd_data;
        push        = 1'b0;
        flush_done  = 1'b0;

        case (state)
            ST_RUN:   if (flush)  state_nxt = ST_FLUSH;
            ST_FLUSH: if (!flush) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase

        // A load that misses the buffer owns the memory port this cycle.
        load_miss = pipe.mem_re && !pipe.mem_we && (state == ST_RUN) && !hit;

        if (load_miss) begin
            dm_re   = 1'b1;
            dm_addr = pipe.mem_addr;
        end else if (count != '0) begin
            dm_we = 1'b1;
        end

        if (conflict) begin
            pipe.stall = 1'b0;
        end else if (state == ST_FLUSH) begin
            pipe.stall = pipe.mem_re | pipe.mem_we;
        end else if (pipe.mem_we) begin
            pipe.stall = full;
        end else if (pipe.mem_re && hit) begin
`ifdef STORE_FWD_EN
            pipe.stall     = 1'b0;
            pipe.mem_rdata = hit_data;
`else
            pipe.stall     = 1'b1;
`endif
        end

        push       = pipe.mem_we && !pipe.mem_re && (state == ST_RUN) && !full;
        flush_done = (state == ST_FLUSH) && flush && (count == '0);
    end

    assign pop = dm_we;

    // State, pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_q | conflict;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; validity is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= pipe.mem_addr;
            data_q[wr_ptr] <= pipe.mem_wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based model of the buffer
// and an architectural memory image (value of the youngest accepted store).
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        flush_done;
    logic        err;
    logic [15:0] dm_addr;
    logic        dm_re;
    logic        dm_we;
    logic [15:0] dm_wrt_data;
    logic [15:0] dm_rd_data;

    store_buffer_if pif ();

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe        (pif),
        .flush       (flush),
        .flush_done  (flush_done),
        .err         (err),
        .dm_addr     (dm_addr),
        .dm_re       (dm_re),
        .dm_we       (dm_we),
        .dm_wrt_data (dm_wrt_data),
        .dm_rd_data  (dm_rd_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write during the clock-low phase.
    logic [15:0] dmem [0:511];
    assign dm_rd_data = dm_re ? dmem[dm_addr[8:0]] : 16'h0000;
    always @(negedge clk) if (rst_n && dm_we) dmem[dm_addr[8:0]] <= dm_wrt_data;

    // Behavioural model state.
    typedef struct { logic [15:0] a; logic [15:0] d; } ent_t;
    ent_t        q[$];
    logic [15:0] arch [0:511];
    bit          m_flush;
    bit          m_err;
    bit          chk_en;
    int          checks;
    int          failures;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_flush = 0;
        m_err   = 0;
        for (int i = 0; i < 512; i++) arch[i] = dmem[i];
    endtask

    // Compare DUT outputs with the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            bit re, we, conflict, hit, miss, e_re, e_we, e_stall, full;
            re       = pif.mem_re;
            we       = pif.mem_we;
            conflict = re && we;
            hit      = 0;
            foreach (q[k]) if (q[k].a == pif.mem_addr) hit = 1;
            full     = (q.size() == DEPTH);
            miss     = re && !we && !m_flush && !hit;
            e_re     = miss;
            e_we     = !miss && (q.size() > 0);
            if (conflict)            e_stall = 0;
            else if (m_flush)        e_stall = re || we;
            else if (we)             e_stall = full;
`ifdef STORE_FWD_EN
            else if (re && hit)      e_stall = 0;
`else
            else if (re && hit)      e_stall = 1;
`endif
            else                     e_stall = 0;

            check("dm_re", dm_re, e_re);
            check("dm_we", dm_we, e_we);
            check("dm_re_we_excl", dm_re & dm_we, 0);
            check("stall", pif.stall, e_stall);
            check("flush_done", flush_done, m_flush && flush && (q.size() == 0));
            check("err", err, m_err);
            if (e_re) check("dm_addr_load", dm_addr, pif.mem_addr);
            if (e_we) begin
                check("dm_addr_drain", dm_addr, q[0].a);
                check("dm_wrt_data", dm_wrt_data, q[0].d);
            end
            if (re && !we && !e_stall)
                check("mem_rdata", pif.mem_rdata, arch[pif.mem_addr[8:0]]);

            if (e_we) void'(q.pop_front());
            if (we && !re && !m_flush && !full) begin
                q.push_back('{a: pif.mem_addr, d: pif.mem_wdata});
                arch[pif.mem_addr[8:0]] = pif.mem_wdata;
            end
            if (conflict) m_err = 1;
            m_flush = flush;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic peek();
        @(negedge clk); #1;
    endtask

    task automatic idle_inputs();
        pif.mem_re = 0; pif.mem_we = 0; pif.mem_addr = 0; pif.mem_wdata = 0;
    endtask

    // Present one op and hold it until the buffer accepts it (bounded).
    task automatic op(input bit re, input bit we, input logic [15:0] a,
                      input logic [15:0] d, output logic [15:0] rd);
        bit done;
        done = 0;
        rd   = 16'h0;
        pif.mem_re = re; pif.mem_we = we; pif.mem_addr = a; pif.mem_wdata = d;
        for (int n = 0; n < 64 && !done; n++) begin
            peek();
            if (!pif.stall) begin
                rd   = pif.mem_rdata;
                done = 1;
            end
            cyc();
        end
        if (!done) begin
            failures++;
            $display("FAIL op_timeout addr=%h actual=stalled required=accepted", a);
        end
        idle_inputs();
    endtask

    logic [15:0] rd;
    int          n_we;
    bit          seen;

    initial begin
        rst_n = 0; flush = 0; chk_en = 0; checks = 0; failures = 0;
        idle_inputs();
        for (int i = 0; i < 512; i++) dmem[i] = 16'(i * 7) ^ 16'h5A5A;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        peek();
        check("reset_dm_we", dm_we, 0);
        check("reset_dm_re", dm_re, 0);
        check("reset_stall", pif.stall, 0);
        check("reset_err", err, 0);
        check("reset_flush_done", flush_done, 0);
        cyc();
        rst_n = 1; chk_en = 1;
        cyc();

        // Single store drains on the following cycle.
        op(0, 1, 16'h0010, 16'hBEEF, rd);
        peek();
        check("t1_dm_we", dm_we, 1);
        check("t1_dm_addr", dm_addr, 16'h0010);
        check("t1_dm_wrt_data", dm_wrt_data, 16'hBEEF);
        cyc();
        peek();
        check("t1_empty", dm_we, 0);
        cyc();

        // Stores interleaved with missing loads.
        for (int i = 0; i < 5; i++) begin
            op(0, 1, 16'h0020 + 16'(i), 16'($urandom), rd);
            op(1, 0, 16'h0100, 16'h0, rd);
        end
        repeat (6) cyc();

        // Two stores to one address then a load: youngest value must come back.
        op(0, 1, 16'h0030, 16'h1111, rd);
        op(0, 1, 16'h0030, 16'h2222, rd);
        op(1, 0, 16'h0030, 16'h0, rd);
        check("t3_rdata", rd, 16'h2222);
        repeat (6) cyc();

        // Flush: one entry remains after two stores, so exactly one drain.
        op(0, 1, 16'h0040, 16'hAAAA, rd);
        op(0, 1, 16'h0041, 16'hBBBB, rd);
        flush = 1;
        n_we = 0; seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            peek();
            if (flush_done) seen = 1;
            else begin
                if (dm_we) n_we++;
                cyc();
            end
        end
        check("t4_flush_done", flush_done, 1);
        check("t4_drain_count", 16'(n_we), 16'd1);
        cyc();
        pif.mem_re = 1; pif.mem_addr = 16'h0100;
        peek();
        check("t4_load_stalled", pif.stall, 1);
        cyc();
        idle_inputs();
        flush = 0;
        cyc();
        cyc();
        pif.mem_re = 1; pif.mem_addr = 16'h0101;
        peek();
        check("t4_run_no_stall", pif.stall, 0);
        cyc();
        idle_inputs();

        // Simultaneous load and store.
        pif.mem_re = 1; pif.mem_we = 1; pif.mem_addr = 16'h0050; pif.mem_wdata = 16'hDEAD;
        peek();
        check("t5_stall", pif.stall, 0);
        check("t5_dm_re", dm_re, 0);
        cyc();
        idle_inputs();
        peek();
        check("t5_err", err, 1);
        repeat (3) cyc();
        peek();
        check("t5_err_sticky", err, 1);
        cyc();

        // Reset with a store pending.
        op(0, 1, 16'h0060, 16'h7777, rd);
        rst_n = 0;
        model_reset();
        #1;
        check("t6_dm_we_reset", dm_we, 0);
        check("t6_err_reset", err, 0);
        cyc();
        rst_n = 1;
        repeat (4) cyc();
        check("t6_no_stale_write", dmem[9'h060], arch[9'h060]);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [15:0] a;
            r = int'($urandom_range(0, 99));
            a = ($urandom_range(0, 1) != 0) ? 16'h0030 + 16'($urandom_range(0, 7))
                                            : 16'h0100 + 16'($urandom_range(0, 7));
            pif.mem_addr  = a;
            pif.mem_wdata = 16'($urandom);
            pif.mem_re    = (r >= 35 && r < 70) || r == 99;
            pif.mem_we    = (r < 35) || r == 99;
            if (flush) flush = ($urandom_range(0, 9) >= 2);
            else       flush = ($urandom_range(0, 99) < 3);
            cyc();
        end
        idle_inputs();
        flush = 1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            peek();
            if (flush_done) seen = 1;
            else cyc();
        end
        check("final_flush_done", flush_done, 1);
        cyc();
        flush = 0;
        cyc();
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 512; i++) if (dmem[i] !== arch[i]) bad++;
            check("final_memory_image", 16'(bad), 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
